screen_sequencer: RTL
=====================

# screen_sequencer

Top-level game-flow controller for the Whack-a-mole VGA display. It sequences the three full-screen renderers (title, play field, game-over text) and decides which one drives the VGA colour outputs. It owns the round countdown and the BCD score, and swaps screens only on frame boundaries so the display never tears mid-frame. It sits between the button/mole logic and the screen renderers, and takes its frame pulse from `vga_sync`.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100_000_000: clk cycles per game second.
- `GAME_SECONDS`, default 30: round length, 1..99.
- `OVER_SECONDS`, default 5: game-over hold time, 1..99.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: start button level, already debounced; the block edge-detects it.
- `hit`, input, 1: one-cycle pulse per successful whack.
- `frame_start`, input, 1: one-cycle pulse at the start of each vsync, from `vga_sync`.
- `screen_sel`, output, 2: 0 = title, 1 = play, 2 = game over; 3 is never driven.
- `game_active`, output, 1: high while in PLAY; enables the mole logic.
- `time_left`, output, 7: remaining seconds, binary.
- `score_bcd`, output, 8: two BCD digits; tens in [7:4], ones in [3:0].

## Operation
- State machine:
  - TITLE: on a rising edge of `start`, go to PLAY.
  - PLAY: when the second tick takes `time_left` from 1 to 0, go to OVER.
  - OVER: after `OVER_SECONDS` second ticks, go to TITLE.
- Start detection:
  - Rising edge = `start` & ~`start_q`, where `start_q` is `start` registered.
  - Edges are ignored in PLAY and OVER.
  - A button held from OVER into TITLE does not restart; a new edge is required.
- Entering PLAY:
  - `time_left` ← `GAME_SECONDS`.
  - `score_bcd` ← 0.
  - Second prescaler cleared.
- Entering OVER:
  - Prescaler cleared.
  - Hold counter ← `OVER_SECONDS`.
  - `score_bcd` freezes and stays visible through OVER and TITLE.
- Score:
  - Each `hit` while in PLAY increments `score_bcd` in BCD: ones wrap 9→0 with a carry into tens.
  - Saturates at 0x99.
  - `hit` outside PLAY is ignored.
- `game_active` = (state == PLAY), a registered decode.
- `screen_sel` is a register. It loads the code for the current state only on a cycle where `frame_start` is high; otherwise it holds.

## Timing
- Reset values:
  - State TITLE, `screen_sel` = 0, `game_active` = 0.
  - `time_left` = 0, `score_bcd` = 0x00, prescaler = 0, `start_q` = 0.
- Start latency: the rising edge of `start` is seen in cycle N. State and `game_active` change at the N+1 edge. `screen_sel` changes at the first `frame_start` after that.
- Second tick: a one-cycle pulse when the prescaler reaches `TICKS_PER_SEC`−1; the prescaler then wraps to 0.
  - First tick after entering PLAY or OVER comes exactly `TICKS_PER_SEC` cycles after entry.
- Simultaneous events:
  - `hit` on the same cycle as the final tick is counted, because state is still PLAY that cycle.
  - A state change and `frame_start` in the same cycle: `screen_sel` loads the old state's code. The new code loads on the next frame.
- `reset` mid-round: everything returns to reset values on the next edge, with no partial updates.

## Configuration
- `SEQ_PAUSE_EN`, when defined:
  - Adds input port `pause` (1 bit) and a PAUSED state.
  - A rising edge of `pause` in PLAY goes to PAUSED; a rising edge of `pause` in PAUSED returns to PLAY.
  - In PAUSED: prescaler frozen, `hit` ignored, `game_active` = 0, `screen_sel` target = 1.
- When not defined: no `pause` port and no PAUSED state; the state register stays 2 bits.

## Structure
- Package `screen_pkg` holds:
  - State encoding constants: TITLE, PLAY, OVER, PAUSED.
  - Screen codes: SCR_TITLE = 0, SCR_PLAY = 1, SCR_OVER = 2.
  - The BCD digit width.
- One sub-module, `sec_timer`:
  - Parameterised on `TICKS_PER_SEC`.
  - Inputs: `clk`, `reset`, `clear`, `enable`.
  - Output: `tick`.
  - Instantiated once and shared by PLAY and OVER.

## Test plan
All scenarios use `TICKS_PER_SEC` = 10, `GAME_SECONDS` = 3, `OVER_SECONDS` = 2, and `frame_start` every 7 cycles.
- Reset, then idle for 100 cycles → `screen_sel` = 0, `game_active` = 0, `score_bcd` = 0x00.
- `start` edge → `game_active` = 1 the next cycle, `time_left` = 3. `screen_sel` = 1 only after the next `frame_start`. `time_left` reads 2, 1 at 10-cycle steps; at 0 `game_active` = 0 and the state is OVER.
- 12 `hit` pulses in PLAY → `score_bcd` = 0x12. With 105 hits in PLAY (use `GAME_SECONDS` = 99 for this case) → `score_bcd` = 0x99, saturated. A `hit` in OVER leaves it unchanged.
- `hit` coincident with the final tick → counted. OVER lasts 20 cycles, then TITLE with `score_bcd` still shown.
- `start` held high from PLAY through return to TITLE → no restart. Release, then re-press → PLAY with `score_bcd` = 0x00.
- `reset` asserted mid-PLAY with `time_left` = 2 → next cycle state TITLE, all outputs at reset values. With `SEQ_PAUSE_EN` defined: `pause` edge freezes `time_left` for 50 cycles, a second edge resumes it.

Source files
------------

// File: rtl/screen_pkg.sv
// screen_pkg: shared state codes, screen codes and BCD helpers
// for the whack-a-mole screen sequencer.
package screen_pkg;

  typedef enum logic [1:0] {
    TITLE  = 2'd0,
    PLAY   = 2'd1,
    OVER   = 2'd2,
    PAUSED = 2'd3
  } state_t;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_PLAY  = 2'd1;
  localparam logic [1:0] SCR_OVER  = 2'd2;

  localparam int BCD_W = 4;

  localparam logic [2*BCD_W-1:0] BCD_MAX = 8'h99;

  function automatic logic [2*BCD_W-1:0] bcd_inc(
    input logic [2*BCD_W-1:0] v
  );
    logic [BCD_W-1:0] ones;
    logic [BCD_W-1:0] tens;
    ones = v[BCD_W-1:0];
    tens = v[2*BCD_W-1:BCD_W];
    if (v == BCD_MAX) return v;
    if (ones == 4'd9) begin
      ones = '0;
      tens = tens + 1'b1;
    end else begin
      ones = ones + 1'b1;
    end
    return {tens, ones};
  endfunction

  // Paused still shows the play field.
  function automatic logic [1:0] scr_code(input state_t s);
    case (s)
      PLAY:    return SCR_PLAY;
      PAUSED:  return SCR_PLAY;
      OVER:    return SCR_OVER;
      default: return SCR_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/screen_sequencer_sec_timer.sv
// sec_timer: game-second prescaler, one-cycle tick every
// TICKS_PER_SEC enabled cycles; clear restarts the second.
module sec_timer #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: title/play/over flow, round timer, BCD score,
// frame-aligned screen_sel. Optional SEQ_PAUSE_EN adds pause/PAUSED.
// Ports: clk, reset, start, hit, frame_start, [pause] ->
//   screen_sel[1:0], game_active, time_left[6:0], score_bcd[7:0].
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int GAME_SECONDS  = 30,
  parameter int OVER_SECONDS  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       frame_start,
`ifdef SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] screen_sel,
  output logic       game_active,
  output logic [6:0] time_left,
  output logic [7:0] score_bcd
);

  state_t     state;
  state_t     next_state;
  logic       start_q;
  logic       start_rise;
  logic [6:0] hold;
  logic       tick;
  logic       timer_en;
  logic       timer_clear;

  assign start_rise = start & ~start_q;

`ifdef SEQ_PAUSE_EN
  logic pause_q;
  logic pause_rise;

  assign pause_rise = pause & ~pause_q;

  always_ff @(posedge clk) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause;
  end
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      TITLE: if (start_rise) next_state = PLAY;
      PLAY: begin
        if (tick && time_left == 7'd1) next_state = OVER;
`ifdef SEQ_PAUSE_EN
        else if (pause_rise) next_state = PAUSED;
`endif
      end
      OVER: if (tick && hold == 7'd1) next_state = TITLE;
`ifdef SEQ_PAUSE_EN
      PAUSED: if (pause_rise) next_state = PLAY;
`endif
      default: next_state = TITLE;
    endcase
  end

  // Resume from pause keeps the partial second.
  assign timer_en    = (state == PLAY) || (state == OVER);
  assign timer_clear = (next_state != state) &&
                       (state == TITLE || next_state == OVER);

  sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= TITLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q     <= 1'b0;
      game_active <= 1'b0;
      screen_sel  <= SCR_TITLE;
      time_left   <= '0;
      score_bcd   <= '0;
      hold        <= '0;
    end else begin
      start_q     <= start;
      game_active <= (next_state == PLAY);
      // Old state's code on a coincident change: no mid-frame swap.
      if (frame_start) screen_sel <= scr_code(state);
      if (state == TITLE && next_state == PLAY) begin
        time_left <= 7'(GAME_SECONDS);
        score_bcd <= '0;
      end else if (state == PLAY) begin
        if (tick) time_left <= time_left - 1'b1;
        if (hit)  score_bcd <= bcd_inc(score_bcd);
      end
      if (state == PLAY && next_state == OVER)
        hold <= 7'(OVER_SECONDS);
      else if (state == OVER && tick)
        hold <= hold - 1'b1;
    end
  end

endmodule
